// File: rtl/padder_arbiter.sv
// padder_arbiter: round-robin front end that shares one pipelined adder
// among NUM_REQ requesters, with a tag pipeline routing each result home.
//
// Ports
//   Clock, Reset_n        rising-edge clock, synchronous active-low reset
//   Req_valid/Req_ready   per-requester handshake; Req_ready is a one-hot grant
//   Req_A/Req_B/Req_CI    packed per-requester operands (requester i at [i*WIDTH +: WIDTH])
//   Hold                  blocks new issues; in-flight operations still retire
//   Add_A/Add_B/Add_CI    operands to the shared adder (zero when nothing issues)
//   Add_S/Add_CO          adder result, LATENCY cycles after the operands
//   Rsp_valid             one-hot owner of the result presented this cycle
//   Rsp_S/Rsp_CO          adder result passthrough
//   In_flight             number of operations currently inside the adder
//   Issue_count           saturating count of issued operations
module padder_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 4
) (
    input  logic                           Clock,
    input  logic                           Reset_n,
    input  logic [NUM_REQ-1:0]             Req_valid,
    output logic [NUM_REQ-1:0]             Req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]       Req_A,
    input  logic [NUM_REQ*WIDTH-1:0]       Req_B,
    input  logic [NUM_REQ-1:0]             Req_CI,
    input  logic                           Hold,
    output logic [WIDTH-1:0]               Add_A,
    output logic [WIDTH-1:0]               Add_B,
    output logic                           Add_CI,
    input  logic [WIDTH-1:0]               Add_S,
    input  logic                           Add_CO,
    output logic [NUM_REQ-1:0]             Rsp_valid,
    output logic [WIDTH-1:0]               Rsp_S,
    output logic                           Rsp_CO,
    output logic [$clog2(LATENCY+1)-1:0]   In_flight,
    output logic [15:0]                    Issue_count
);

    localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]    tag_id_q [LATENCY];
    logic [ID_W-1:0]    tag_id_d [LATENCY];
    logic [CNT_W-1:0]   in_flight_q, in_flight_d;
    logic [15:0]        issue_cnt_q, issue_cnt_d;

    logic [NUM_REQ-1:0] gnt_c;
    logic [ID_W-1:0]    gnt_id_c;
    logic               issue_c;
    logic               retire_c;
    logic [31:0]        idx_c;

    // Round-robin grant: first valid requester strictly after the pointer, wrapping.
    always_comb begin : grant
        gnt_c    = '0;
        gnt_id_c = '0;
        issue_c  = 1'b0;
        idx_c    = '0;
        if (Reset_n && !Hold) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                idx_c = 32'(ptr_q) + k;
                if (idx_c >= NUM_REQ) begin
                    idx_c = idx_c - NUM_REQ;
                end
                if (!issue_c && Req_valid[ID_W'(idx_c)]) begin
                    issue_c                = 1'b1;
                    gnt_id_c               = ID_W'(idx_c);
                    gnt_c[ID_W'(idx_c)]    = 1'b1;
                end
            end
        end
    end

    assign Req_ready = gnt_c;

    // Operand mux onto the shared adder; idle cycles drive zeros.
    always_comb begin : operand_mux
        Add_A  = '0;
        Add_B  = '0;
        Add_CI = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_c[i]) begin
                Add_A  = Req_A[i*WIDTH +: WIDTH];
                Add_B  = Req_B[i*WIDTH +: WIDTH];
                Add_CI = Req_CI[i];
            end
        end
    end

    assign retire_c = tag_vld_q[LATENCY-1];

    // Result routing: the adder has no reset, so only a valid tag exposes its output.
    always_comb begin : response
        Rsp_valid = '0;
        if (Reset_n && retire_c) begin
            Rsp_valid[tag_id_q[LATENCY-1]] = 1'b1;
        end
    end

    assign Rsp_S       = Add_S;
    assign Rsp_CO      = Add_CO;
    assign In_flight   = in_flight_q;
    assign Issue_count = issue_cnt_q;

    // Next-state: tag shift, pointer, occupancy and saturating issue counter.
    always_comb begin : next_state
        tag_vld_d    = '0;
        tag_vld_d[0] = issue_c;
        for (int k = 0; k < int'(LATENCY); k++) begin
            tag_id_d[k] = '0;
        end
        tag_id_d[0] = gnt_id_c;
        for (int k = 1; k < int'(LATENCY); k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end

        ptr_d = issue_c ? gnt_id_c : ptr_q;

        in_flight_d = in_flight_q;
        if (issue_c && !retire_c) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (!issue_c && retire_c) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end

        issue_cnt_d = issue_cnt_q;
        if (issue_c && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
    end

    // State registers; reset drops every in-flight tag.
    always_ff @(posedge Clock) begin : regs
        if (!Reset_n) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            tag_vld_q   <= '0;
            in_flight_q <= '0;
            issue_cnt_q <= '0;
            for (int k = 0; k < int'(LATENCY); k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            tag_vld_q   <= tag_vld_d;
            in_flight_q <= in_flight_d;
            issue_cnt_q <= issue_cnt_d;
            for (int k = 0; k < int'(LATENCY); k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
        end
    end

endmodule
